// File: rtl/csv_field_parser.sv
// csv_field_parser
// Streaming CSV tokenizer with RFC-4180 quoting. Bytes arrive on a valid/ready
// input and leave as one-byte tokens tagged with column index and
// end-of-field / end-of-record / empty-field markers.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      input byte stream
//   out_data/out_valid/out_ready   output token stream
//   out_col                 column index of the token
//   out_eof/out_eor         last byte of field / last byte of record
//   out_empty               zero-length field token (out_data is 0)
//   err_clr                 clears the sticky error flags
//   err_quote/err_cols      sticky: bad byte after closing quote / too many columns
//   rec_count/fld_count     completed record / field counters
//
// Optional feature macro: CSV_STATS_EN adds rec_count and fld_count.
module csv_field_parser #(
    parameter logic [7:0] DELIM    = 8'h2C,
    parameter logic [7:0] QUOTE    = 8'h22,
    parameter int         MAX_COLS = 8,
    parameter int         COL_W    = $clog2(MAX_COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] out_col,
    output logic             out_eof,
    output logic             out_eor,
    output logic             out_empty,
    input  logic             err_clr,
    output logic             err_quote,
`ifdef CSV_STATS_EN
    output logic [31:0]      rec_count,
    output logic [31:0]      fld_count,
`endif
    output logic             err_cols
);

    localparam logic [7:0]       LF       = 8'h0A;
    localparam logic [7:0]       CR       = 8'h0D;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_COLS - 1);

    typedef enum logic [1:0] {START, UNQ, QUO, QSEEN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       p_data_q, p_data_d;
    logic             p_valid_q, p_valid_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             o_valid_q, o_valid_d;
    logic [7:0]       o_data_q, o_data_d;
    logic [COL_W-1:0] o_col_q, o_col_d;
    logic             o_eof_q, o_eof_d;
    logic             o_eor_q, o_eor_d;
    logic             o_empty_q, o_empty_d;
    logic             err_quote_q, err_quote_d;
    logic             err_cols_q, err_cols_d;

    logic accept;
    logic out_fire;
    logic is_data;
    logic is_term;
    logic is_eor;
    logic quote_evt;
    logic cols_evt;

    // O is free to take a new token when empty or being drained this cycle.
    assign in_ready = !o_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_fire = o_valid_q && out_ready;

    // Classify the accepted byte, then apply the shared "data byte" and
    // "field terminator" actions, which are identical across states.
    always_comb begin
        state_d     = state_q;
        p_data_d    = p_data_q;
        p_valid_d   = p_valid_q;
        col_d       = col_q;
        o_valid_d   = out_fire ? 1'b0 : o_valid_q;
        o_data_d    = o_data_q;
        o_col_d     = o_col_q;
        o_eof_d     = o_eof_q;
        o_eor_d     = o_eor_q;
        o_empty_d   = o_empty_q;
        is_data     = 1'b0;
        is_term     = 1'b0;
        is_eor      = 1'b0;
        quote_evt   = 1'b0;
        cols_evt    = 1'b0;

        if (accept) begin
            case (state_q)
                START: begin
                    if (in_data == QUOTE) begin
                        state_d = QUO;
                    end else if (in_data == DELIM) begin
                        is_term = 1'b1;
                    end else if (in_data == LF) begin
                        is_term = 1'b1;
                        is_eor  = 1'b1;
                    end else if (in_data != CR) begin
                        is_data = 1'b1;
                        state_d = UNQ;
                    end
                end
                UNQ: begin
                    if (in_data == DELIM) begin
                        is_term = 1'b1;
                    end else if (in_data == LF) begin
                        is_term = 1'b1;
                        is_eor  = 1'b1;
                    end else if (in_data != CR) begin
                        is_data = 1'b1;
                    end
                end
                QUO: begin
                    if (in_data == QUOTE) begin
                        state_d = QSEEN;
                    end else begin
                        is_data = 1'b1;
                    end
                end
                default: begin
                    if (in_data == QUOTE) begin
                        is_data = 1'b1;
                        state_d = QUO;
                    end else if (in_data == DELIM) begin
                        is_term = 1'b1;
                    end else if (in_data == LF) begin
                        is_term = 1'b1;
                        is_eor  = 1'b1;
                    end else if (in_data != CR) begin
                        quote_evt = 1'b1;
                        is_data   = 1'b1;
                        state_d   = UNQ;
                    end
                end
            endcase
        end

        // A new data byte pushes the previously held byte out as a plain token.
        if (is_data) begin
            if (p_valid_q) begin
                o_valid_d = 1'b1;
                o_data_d  = p_data_q;
                o_col_d   = col_q;
                o_eof_d   = 1'b0;
                o_eor_d   = 1'b0;
                o_empty_d = 1'b0;
            end
            p_data_d  = in_data;
            p_valid_d = 1'b1;
        end

        // Terminator flushes the held byte with eof, or an empty token if none.
        if (is_term) begin
            o_valid_d = 1'b1;
            o_data_d  = p_valid_q ? p_data_q : 8'h00;
            o_col_d   = col_q;
            o_eof_d   = 1'b1;
            o_eor_d   = is_eor;
            o_empty_d = !p_valid_q;
            p_valid_d = 1'b0;
            state_d   = START;
            if (is_eor) begin
                col_d = '0;
            end else if (col_q == LAST_COL) begin
                cols_evt = 1'b1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // A new error event wins over a simultaneous clear.
        err_quote_d = (err_quote_q && !err_clr) || quote_evt;
        err_cols_d  = (err_cols_q && !err_clr) || cols_evt;
    end

    // Parser state, pending byte, output token and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= START;
            p_data_q    <= 8'h00;
            p_valid_q   <= 1'b0;
            col_q       <= '0;
            o_valid_q   <= 1'b0;
            o_data_q    <= 8'h00;
            o_col_q     <= '0;
            o_eof_q     <= 1'b0;
            o_eor_q     <= 1'b0;
            o_empty_q   <= 1'b0;
            err_quote_q <= 1'b0;
            err_cols_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_data_q    <= p_data_d;
            p_valid_q   <= p_valid_d;
            col_q       <= col_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_col_q     <= o_col_d;
            o_eof_q     <= o_eof_d;
            o_eor_q     <= o_eor_d;
            o_empty_q   <= o_empty_d;
            err_quote_q <= err_quote_d;
            err_cols_q  <= err_cols_d;
        end
    end

    assign out_valid = o_valid_q;
    assign out_data  = o_data_q;
    assign out_col   = o_col_q;
    assign out_eof   = o_eof_q;
    assign out_eor   = o_eor_q;
    assign out_empty = o_empty_q;
    assign err_quote = err_quote_q;
    assign err_cols  = err_cols_q;

`ifdef CSV_STATS_EN
    logic [31:0] rec_count_q, rec_count_d;
    logic [31:0] fld_count_q, fld_count_d;

    // Counters advance when the token actually leaves, not when it is formed.
    always_comb begin
        rec_count_d = rec_count_q;
        fld_count_d = fld_count_q;
        if (out_fire && o_eor_q) begin
            rec_count_d = rec_count_q + 32'd1;
        end
        if (out_fire && o_eof_q) begin
            fld_count_d = fld_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_count_q <= 32'd0;
            fld_count_q <= 32'd0;
        end else begin
            rec_count_q <= rec_count_d;
            fld_count_q <= fld_count_d;
        end
    end

    assign rec_count = rec_count_q;
    assign fld_count = fld_count_q;
`endif

endmodule

// File: tb/tb_csv_field_parser.sv
// tb_csv_field_parser
// Drives directed and random CSV records into csv_field_parser. Each record is
// described as a list of field contents; the expected token stream is derived
// from that list and pushed to a scoreboard before the encoded bytes are sent.
module tb_csv_field_parser;

    localparam int         MAX_COLS = 4;
    localparam int         COL_W    = $clog2(MAX_COLS);
    localparam logic [7:0] DELIM    = 8'h2C;
    localparam logic [7:0] QUOTE    = 8'h22;

    logic             clk;
    logic             rst_n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [COL_W-1:0] out_col;
    logic             out_eof;
    logic             out_eor;
    logic             out_empty;
    logic             err_clr;
    logic             err_quote;
    logic             err_cols;
`ifdef CSV_STATS_EN
    logic [31:0]      rec_count;
    logic [31:0]      fld_count;
`endif

    typedef struct packed {
        logic             empty;
        logic             eor;
        logic             eof;
        logic [COL_W-1:0] col;
        logic [7:0]       data;
    } tok_t;

    tok_t       expQ[$];
    logic [7:0] rawQ[$];
    logic [7:0] fldData[$];
    int         fldLen[$];
    int         checks = 0;
    int         failures = 0;
    int         readyMode = 0;
    bit         expQuote = 0;
    bit         expCols = 0;
    bit         stallPrev = 0;
    tok_t       prevTok;
`ifdef CSV_STATS_EN
    int         expRec = 0;
    int         expFld = 0;
`endif

    csv_field_parser #(.DELIM(DELIM), .QUOTE(QUOTE), .MAX_COLS(MAX_COLS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_eof(out_eof), .out_eor(out_eor), .out_empty(out_empty),
        .err_clr(err_clr), .err_quote(err_quote),
`ifdef CSV_STATS_EN
        .rec_count(rec_count), .fld_count(fld_count),
`endif
        .err_cols(err_cols)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer side: out_ready pattern selected by readyMode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks that a
    // stalled token stays put while input is back-pressured.
    always @(negedge clk) begin
        tok_t act;
        act = '{empty: out_empty, eor: out_eor, eof: out_eof, col: out_col, data: out_data};
        if (!rst_n) begin
            stallPrev = 0;
        end else begin
            if (stallPrev) begin
                checkOutput("hold", 32'({out_valid, act}), 32'({1'b1, prevTok}));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_token", 32'(act), 32'hFFFFFFFF);
                end else begin
                    tok_t e;
                    e = expQ.pop_front();
                    checkOutput("token", 32'(act), 32'(e));
`ifdef CSV_STATS_EN
                    expRec += int'(e.eor);
                    expFld += int'(e.eof);
`endif
                end
            end
            if (out_valid && !out_ready) begin
                checkOutput("in_ready_stall", 32'(in_ready), 32'd0);
                prevTok   = act;
                stallPrev = 1;
            end else begin
                stallPrev = 0;
            end
        end
    end

    task automatic addField(input string s);
        fldLen.push_back(s.len());
        for (int i = 0; i < s.len(); i++) fldData.push_back(s[i]);
    endtask

    task automatic loadRaw(input string s);
        for (int i = 0; i < s.len(); i++) rawQ.push_back(s[i]);
    endtask

    // Expected tokens follow directly from the field list.
    task automatic pushExpected();
        int idx = 0;
        int n   = fldLen.size();
        for (int f = 0; f < n; f++) begin
            int  col  = (f < MAX_COLS - 1) ? f : MAX_COLS - 1;
            bit  last = (f == n - 1);
            if (f >= MAX_COLS - 1 && !last) expCols = 1;
            if (fldLen[f] == 0) begin
                expQ.push_back('{empty: 1'b1, eor: last, eof: 1'b1, col: COL_W'(col), data: 8'h00});
            end else begin
                for (int b = 0; b < fldLen[f]; b++) begin
                    bit endf = (b == fldLen[f] - 1);
                    expQ.push_back('{empty: 1'b0, eor: last && endf, eof: endf,
                                     col: COL_W'(col), data: fldData[idx]});
                    idx++;
                end
            end
        end
        fldLen.delete();
        fldData.delete();
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int cnt = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 1000) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendRaw();
        while (rawQ.size() != 0) applyStimulus(rawQ.pop_front());
    endtask

    task automatic drainAndCheck();
        int n = 0;
        while (expQ.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("err_quote", 32'(err_quote), 32'(expQuote));
        checkOutput("err_cols", 32'(err_cols), 32'(expCols));
`ifdef CSV_STATS_EN
        checkOutput("rec_count", rec_count, 32'(expRec));
        checkOutput("fld_count", fld_count, 32'(expFld));
`endif
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checkOutput("err_quote_clr", 32'(err_quote), 32'd0);
        checkOutput("err_cols_clr", 32'(err_cols), 32'd0);
        expQuote = 0;
        expCols  = 0;
    endtask

    task automatic runRecord();
        pushExpected();
        sendRaw();
        drainAndCheck();
    endtask

    function automatic logic [7:0] pickChar(input int k);
        case (k)
            0:       return 8'h61;
            1:       return 8'h62;
            2:       return 8'h78;
            3:       return DELIM;
            4:       return QUOTE;
            5:       return 8'h0A;
            6:       return 8'h0D;
            default: return 8'h31;
        endcase
    endfunction

    // Random record: fields with special bytes are quoted (quotes doubled),
    // plain fields are quoted only sometimes.
    task automatic randomRecord();
        int n = $urandom_range(1, 6);
        for (int f = 0; f < n; f++) begin
            logic [7:0] content[$];
            int  len     = $urandom_range(0, 4);
            bit  special = 0;
            bit  quoted;
            for (int i = 0; i < len; i++) begin
                logic [7:0] c = pickChar($urandom_range(0, 7));
                content.push_back(c);
                fldData.push_back(c);
                if (c == DELIM || c == QUOTE || c == 8'h0A || c == 8'h0D) special = 1;
            end
            fldLen.push_back(len);
            quoted = special || ($urandom_range(0, 3) == 0);
            if (quoted) rawQ.push_back(QUOTE);
            foreach (content[i]) begin
                rawQ.push_back(content[i]);
                if (quoted && content[i] == QUOTE) rawQ.push_back(QUOTE);
            end
            if (quoted) rawQ.push_back(QUOTE);
            if (f < n - 1) rawQ.push_back(DELIM);
        end
        if ($urandom_range(0, 1) == 1) rawQ.push_back(8'h0D);
        rawQ.push_back(8'h0A);
        runRecord();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_out_col"}, 32'(out_col), 32'd0);
        checkOutput({tag, "_flags"}, 32'({out_eof, out_eor, out_empty}), 32'd0);
        checkOutput({tag, "_errs"}, 32'({err_quote, err_cols}), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef CSV_STATS_EN
        checkOutput({tag, "_counts"}, rec_count | fld_count, 32'd0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        addField("a"); addField("bc");
        loadRaw("a,bc\n");
        runRecord();

        addField(""); addField(""); addField("");
        loadRaw(",,\n");
        runRecord();

        addField("x,\"y");
        loadRaw("\"x,\"\"y\"");
        rawQ.push_back(8'h0D);
        rawQ.push_back(8'h0A);
        runRecord();

        addField("abc"); addField("");
        loadRaw("\"ab\"c,\n");
        expQuote = 1;
        runRecord();

        // Too many columns, with a 5-cycle consumer stall in the middle.
        readyMode = 1;
        addField("1"); addField("2"); addField("3"); addField("4"); addField("5");
        loadRaw("1,2,3,4,5\n");
        pushExpected();
        fork
            sendRaw();
            begin
                repeat (4) @(posedge clk);
                readyMode = 2;
                repeat (5) @(posedge clk);
                readyMode = 1;
            end
        join
        drainAndCheck();
        readyMode = 0;

        for (int r = 0; r < 40; r++) randomRecord();

        // Reset mid-record discards the partial field and the held token.
        readyMode = 2;
        loadRaw("\"ab");
        sendRaw();
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
`ifdef CSV_STATS_EN
        expRec = 0;
        expFld = 0;
`endif
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        readyMode = 0;
        addField("z");
        loadRaw("z\n");
        runRecord();

        checkOutput("leftover", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
